// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between the EX/MEM pipeline registers,
// the data cache and the memory controller (MC).  It checks each access for
// exceptions and handles byte/half/word formatting.  Cache misses go through
// EVICT/LOAD/FILL, and the controller stalls the pipeline until memDone.
// Optional feature: define MEM_VICTIM_BUF_EN to add a one-entry victim buffer.
// With the buffer, the write-back of a dirty block runs at the same time as
// the refill of the new block.
module mem_stage_ctrl #(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter int         BLK_W       = 512,
  parameter logic [3:0] DATA_REGION = 4'h1,
  parameter logic [3:0] FFT_REGION  = 4'h2,
  parameter int         MC_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     aluResult,
  input  logic [DATA_W-1:0]     read2Data,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            accSize,
  input  logic                  signExt,
  input  logic                  fftCalculating,
  output logic                  cacheEn,
  output logic                  cacheRd,
  output logic                  cacheWr,
  output logic                  cacheLd,
  output logic [ADDR_W-1:0]     cacheAddr,
  output logic [DATA_W-1:0]     cacheDataIn,
  output logic [DATA_W/8-1:0]   cacheByteEn,
  output logic [BLK_W-1:0]      cacheBlkIn,
  input  logic [DATA_W-1:0]     cacheDataOut,
  input  logic                  cacheHit,
  input  logic                  cacheMissIn,
  input  logic                  cacheEvictIn,
  input  logic [BLK_W-1:0]      cacheBlkOut,
  output logic                  mcReq,
  input  logic [BLK_W-1:0]      mcDataIn,
  input  logic                  mcDataValid,
  output logic                  cacheEvict,
  output logic [BLK_W-1:0]      mcDataOut,
  input  logic                  evictDone,
  output logic [DATA_W-1:0]     memoryOut,
  output logic                  memDone,
  output logic                  stallDMAMem,
  output logic                  memAccessEx,
  output logic                  memWriteEx,
  output logic                  fftNotCompleteEx,
  output logic                  misalignEx,
  output logic                  mcTimeoutEx
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(MC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [NBYTES-1:0] BYTE_MASK = 1;
  localparam logic [NBYTES-1:0] HALF_MASK = 3;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, LOAD, FILL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timeoutCnt_q;
  logic               opWrite_q;

  logic [3:0]         region;
  logic [LANE_W-1:0]  lane;
  logic [LANE_W+2:0]  laneShift;
  logic               inData, inFft, inIdle;
  logic               reqRd, reqWr, req, misaligned, anyEx, accept;
  logic               waiting, evictFinish, loadFinish, fillReady, timeoutHit;
  logic [7:0]         loadByte;
  logic [15:0]        loadHalf;
  logic [DATA_W-1:0]  loadData, storeData;
  logic [NBYTES-1:0]  storeEn;

  assign region    = aluResult[ADDR_W-1 -: 4];
  assign lane      = aluResult[LANE_W-1:0];
  assign laneShift = {lane, 3'b000};
  assign inData    = (region == DATA_REGION);
  assign inFft     = (region == FFT_REGION);
  assign inIdle    = (state_q == IDLE);

  // A request is ignored while reset is held, so all outputs stay at 0 during reset.
  // When read and write are both set, the read is serviced.
  assign reqRd = rst & memRead;
  assign reqWr = rst & memWrite & ~memRead;
  assign req   = reqRd | reqWr;

  assign misaligned = ((accSize == 2'd1) & aluResult[0]) |
                      (accSize[1] & (lane != '0));

  assign misalignEx       = inIdle & req & misaligned;
  assign memAccessEx      = inIdle & reqRd & ~inData & ~inFft;
  assign memWriteEx       = inIdle & reqWr & ~inData & ~inFft;
  assign fftNotCompleteEx = inIdle & req & fftCalculating & inFft;
  assign anyEx  = misalignEx | memAccessEx | memWriteEx | fftNotCompleteEx;
  assign accept = inIdle & req & ~anyEx;

  assign waiting    = (state_q == EVICT) | (state_q == LOAD);
  assign loadFinish = (state_q == LOAD) & mcDataValid;
  // A completion that arrives on the timeout cycle takes priority over the abort.
  assign timeoutHit = waiting & (timeoutCnt_q == CNT_LAST) & ~evictFinish & ~loadFinish;

`ifdef MEM_VICTIM_BUF_EN
  logic               victimValid_q;
  logic [BLK_W-1:0]   victimBlk_q;

  assign evictFinish = (state_q == EVICT) & ~victimValid_q;
  assign fillReady   = ~victimValid_q;

  // The victim buffer captures the dirty block in EVICT and holds it until the MC accepts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      victimValid_q <= 1'b0;
      victimBlk_q   <= '0;
    end else if (evictFinish) begin
      victimValid_q <= 1'b1;
      victimBlk_q   <= cacheBlkOut;
    end else if (victimValid_q && evictDone) begin
      victimValid_q <= 1'b0;
      victimBlk_q   <= '0;
    end
  end
`else
  assign evictFinish = (state_q == EVICT) & evictDone;
  assign fillReady   = 1'b1;
`endif

  // Load path: pick the addressed byte or half, then sign- or zero-extend it.
  // Store path: copy the store data into every lane and enable only the target bytes.
  always_comb begin
    loadByte  = 8'(cacheDataOut >> laneShift);
    loadHalf  = 16'(cacheDataOut >> laneShift);
    loadData  = cacheDataOut;
    storeData = read2Data;
    storeEn   = '1;
    case (accSize)
      2'd0: begin
        loadData = {{(DATA_W-8){signExt & loadByte[7]}}, loadByte};
        for (int i = 0; i < NBYTES; i++) storeData[8*i +: 8] = read2Data[7:0];
        storeEn = BYTE_MASK << lane;
      end
      2'd1: begin
        loadData = {{(DATA_W-16){signExt & loadHalf[15]}}, loadHalf};
        for (int i = 0; i < NBYTES/2; i++) storeData[16*i +: 16] = read2Data[15:0];
        storeEn = HALF_MASK << lane;
      end
      default: ;
    endcase
  end

  // Next-state rules.  After FILL the controller retries LOOKUP, which then hits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = LOOKUP;
      LOOKUP: begin
        if (cacheHit)         state_d = IDLE;
        else if (cacheMissIn) state_d = cacheEvictIn ? EVICT : LOAD;
      end
      EVICT: begin
        if (timeoutHit)       state_d = IDLE;
        else if (evictFinish) state_d = LOAD;
      end
      LOAD: begin
        if (timeoutHit)       state_d = IDLE;
        else if (loadFinish)  state_d = FILL;
      end
      FILL:   if (fillReady) state_d = LOOKUP;
      default: state_d = IDLE;
    endcase
  end

  // State register.  The MC wait counter restarts on every state change and counts cycles spent in EVICT or LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      opWrite_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) timeoutCnt_q <= '0;
      else if (waiting)       timeoutCnt_q <= timeoutCnt_q + 1'b1;
      if (accept) opWrite_q <= reqWr;
    end
  end

  // Cache, MC and pipeline controls decoded from the current state.
  always_comb begin
    cacheEn     = 1'b0;
    cacheRd     = 1'b0;
    cacheWr     = 1'b0;
    cacheLd     = 1'b0;
    cacheAddr   = '0;
    cacheDataIn = '0;
    cacheByteEn = '0;
    cacheBlkIn  = '0;
    mcReq       = 1'b0;
    cacheEvict  = 1'b0;
    mcDataOut   = '0;
    memoryOut   = '0;
    memDone     = 1'b0;
    stallDMAMem = 1'b0;
    mcTimeoutEx = timeoutHit;
    if (!inIdle) cacheAddr = aluResult;
    case (state_q)
      IDLE: stallDMAMem = accept;
      LOOKUP: begin
        cacheEn     = 1'b1;
        cacheRd     = ~opWrite_q;
        cacheWr     = opWrite_q;
        cacheByteEn = storeEn;
        cacheDataIn = storeData;
        if (cacheHit) begin
          memDone   = 1'b1;
          memoryOut = opWrite_q ? '0 : loadData;
        end else begin
          stallDMAMem = 1'b1;
        end
      end
      EVICT: stallDMAMem = ~timeoutHit;
      LOAD: begin
        mcReq       = 1'b1;
        cacheLd     = 1'b1;
        cacheBlkIn  = mcDataIn;
        stallDMAMem = ~timeoutHit;
      end
      FILL: stallDMAMem = 1'b1;
      default: ;
    endcase
`ifdef MEM_VICTIM_BUF_EN
    cacheEvict = victimValid_q;
    mcDataOut  = victimBlk_q;
`else
    if (state_q == EVICT) begin
      cacheEvict = 1'b1;
      mcDataOut  = cacheBlkOut;
    end
`endif
  end

endmodule
